// File: rtl/spiflash_arb_pkg.sv
// Shared types, constants and helpers for the two-port SPI flash TileLink-UL Get arbiter.
package spiflash_arb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_D, DENY} arb_state_e;

  localparam int unsigned MAX_SIZE = 9;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  // Number of 32-bit D beats for a Get; sub-word sizes still return a single beat.
  function automatic logic [7:0] size_to_beats(logic [3:0] size);
    if (size <= 4'd2) return 8'd1;
    return 8'd1 << (size - 4'd2);
  endfunction

endpackage

// File: rtl/spiflash_tl_arbiter.sv
// Two-port TileLink-UL Get arbiter sharing one flash controller A/D channel pair.
// Build option: define SPIFLASH_ARB_FIXED_PRIO_EN for fixed port-0 priority instead of round-robin.
module spiflash_tl_arbiter
  import spiflash_arb_pkg::*;
#(
  parameter int unsigned TL_RS    = 3,
  parameter int unsigned MAX_SIZE = spiflash_arb_pkg::MAX_SIZE
) (
  input  logic             flash_clock_i,
  input  logic             flash_reset_i,

  input  logic [3:0]       m0_a_size,
  input  logic [TL_RS-1:0] m0_a_source,
  input  logic [23:0]      m0_a_address,
  input  logic             m0_a_valid,
  output logic             m0_a_ready,
  output logic [2:0]       m0_d_opcode,
  output logic [3:0]       m0_d_size,
  output logic [TL_RS-1:0] m0_d_source,
  output logic             m0_d_denied,
  output logic [31:0]      m0_d_data,
  output logic             m0_d_corrupt,
  output logic             m0_d_valid,
  input  logic             m0_d_ready,

  input  logic [3:0]       m1_a_size,
  input  logic [TL_RS-1:0] m1_a_source,
  input  logic [23:0]      m1_a_address,
  input  logic             m1_a_valid,
  output logic             m1_a_ready,
  output logic [2:0]       m1_d_opcode,
  output logic [3:0]       m1_d_size,
  output logic [TL_RS-1:0] m1_d_source,
  output logic             m1_d_denied,
  output logic [31:0]      m1_d_data,
  output logic             m1_d_corrupt,
  output logic             m1_d_valid,
  input  logic             m1_d_ready,

  output logic [3:0]       flash_a_size,
  output logic [TL_RS:0]   flash_a_source,
  output logic [23:0]      flash_a_address,
  output logic             flash_a_valid,
  input  logic             flash_a_ready,
  input  logic [2:0]       flash_d_opcode,
  input  logic [3:0]       flash_d_size,
  input  logic [TL_RS:0]   flash_d_source,
  input  logic             flash_d_denied,
  input  logic [31:0]      flash_d_data,
  input  logic             flash_d_corrupt,
  input  logic             flash_d_valid,
  output logic             flash_d_ready
);

  arb_state_e       state_q;
  logic             owner_q;
  logic             sel_q;
  logic             lock_q;
  logic             err_q;
  logic [7:0]       beats_q;
  logic [TL_RS-1:0] deny_source_q;
  logic [3:0]       deny_size_q;
  logic             rr_ptr;

`ifndef SPIFLASH_ARB_FIXED_PRIO_EN
  logic rr_ptr_q;
  assign rr_ptr = rr_ptr_q;
`else
  assign rr_ptr = 1'b0;
`endif

  logic [1:0]       a_valid;
  logic [1:0]       a_ready;
  logic [1:0]       d_ready;
  logic [1:0]       d_valid;
  logic [3:0]       a_size    [2];
  logic [TL_RS-1:0] a_source  [2];
  logic [23:0]      a_address [2];

  assign a_valid      = {m1_a_valid, m0_a_valid};
  assign d_ready      = {m1_d_ready, m0_d_ready};
  assign a_size[0]    = m0_a_size;
  assign a_size[1]    = m1_a_size;
  assign a_source[0]  = m0_a_source;
  assign a_source[1]  = m1_a_source;
  assign a_address[0] = m0_a_address;
  assign a_address[1] = m1_a_address;
  assign m0_a_ready   = a_ready[0];
  assign m1_a_ready   = a_ready[1];
  assign m0_d_valid   = d_valid[0];
  assign m1_d_valid   = d_valid[1];

  logic             arb_sel;
  logic             sel;
  logic             sel_valid;
  logic [3:0]       sel_size;
  logic             illegal;
  logic             owner_hit;
  logic [2:0]       rsp_opcode;
  logic [3:0]       rsp_size;
  logic [TL_RS-1:0] rsp_source;
  logic             rsp_denied;
  logic [31:0]      rsp_data;
  logic             rsp_corrupt;

  assign owner_hit = (flash_d_source[TL_RS] == owner_q);

  // A stalled request keeps its grant so a late competitor cannot preempt it.
  always_comb begin
    arb_sel = 1'b0;
    if (a_valid == 2'b10) begin
      arb_sel = 1'b1;
    end else if (a_valid == 2'b11) begin
      arb_sel = rr_ptr;
    end
    sel       = lock_q ? sel_q : arb_sel;
    sel_valid = a_valid[sel];
    sel_size  = a_size[sel];
    illegal   = 32'(sel_size) > MAX_SIZE;
  end

  always_comb begin
    flash_a_valid   = 1'b0;
    flash_a_size    = '0;
    flash_a_source  = '0;
    flash_a_address = '0;
    flash_d_ready   = 1'b0;
    a_ready         = '0;
    d_valid         = '0;
    rsp_opcode      = '0;
    rsp_size        = '0;
    rsp_source      = '0;
    rsp_denied      = 1'b0;
    rsp_data        = '0;
    rsp_corrupt     = 1'b0;
    if (!flash_reset_i) begin
      unique case (state_q)
        IDLE: begin
          flash_d_ready = 1'b1;
          if (sel_valid) begin
            if (illegal) begin
              a_ready[sel] = 1'b1;
            end else begin
              flash_a_valid   = 1'b1;
              flash_a_size    = sel_size;
              flash_a_source  = {sel, a_source[sel]};
              flash_a_address = a_address[sel];
              a_ready[sel]    = flash_a_ready;
            end
          end
        end
        WAIT_D: begin
          rsp_opcode  = flash_d_opcode;
          rsp_size    = flash_d_size;
          rsp_source  = flash_d_source[TL_RS-1:0];
          rsp_denied  = flash_d_denied;
          rsp_data    = flash_d_data;
          rsp_corrupt = flash_d_corrupt;
          if (owner_hit) begin
            d_valid[owner_q] = flash_d_valid;
            flash_d_ready    = d_ready[owner_q];
          end else begin
            flash_d_ready = 1'b1;
          end
        end
        DENY: begin
          flash_d_ready    = 1'b1;
          d_valid[owner_q] = 1'b1;
          rsp_opcode       = TL_ACCESS_ACK_DATA;
          rsp_size         = deny_size_q;
          rsp_source       = deny_source_q;
          rsp_denied       = 1'b1;
          rsp_corrupt      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign m0_d_opcode  = owner_q ? '0 : rsp_opcode;
  assign m0_d_size    = owner_q ? '0 : rsp_size;
  assign m0_d_source  = owner_q ? '0 : rsp_source;
  assign m0_d_denied  = owner_q ? 1'b0 : rsp_denied;
  assign m0_d_data    = owner_q ? '0 : rsp_data;
  assign m0_d_corrupt = owner_q ? 1'b0 : rsp_corrupt;
  assign m1_d_opcode  = owner_q ? rsp_opcode : '0;
  assign m1_d_size    = owner_q ? rsp_size : '0;
  assign m1_d_source  = owner_q ? rsp_source : '0;
  assign m1_d_denied  = owner_q ? rsp_denied : 1'b0;
  assign m1_d_data    = owner_q ? rsp_data : '0;
  assign m1_d_corrupt = owner_q ? rsp_corrupt : 1'b0;

  always_ff @(posedge flash_clock_i) begin
    if (flash_reset_i) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      sel_q         <= 1'b0;
      lock_q        <= 1'b0;
      err_q         <= 1'b0;
      beats_q       <= '0;
      deny_source_q <= '0;
      deny_size_q   <= '0;
`ifndef SPIFLASH_ARB_FIXED_PRIO_EN
      rr_ptr_q      <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (sel_valid && illegal) begin
            owner_q       <= sel;
            deny_source_q <= a_source[sel];
            deny_size_q   <= sel_size;
            lock_q        <= 1'b0;
            state_q       <= DENY;
          end else if (flash_a_valid && flash_a_ready) begin
            owner_q <= sel;
            beats_q <= size_to_beats(sel_size);
            lock_q  <= 1'b0;
            state_q <= WAIT_D;
          end else if (flash_a_valid) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
          end else begin
            lock_q <= 1'b0;
          end
        end
        WAIT_D: begin
          if (flash_d_valid && flash_d_ready && owner_hit) begin
            beats_q <= beats_q - 8'd1;
            if (beats_q == 8'd1) begin
              state_q <= IDLE;
`ifndef SPIFLASH_ARB_FIXED_PRIO_EN
              rr_ptr_q <= ~owner_q;
`endif
            end
          end
        end
        DENY: begin
          if (d_ready[owner_q]) begin
            state_q <= IDLE;
`ifndef SPIFLASH_ARB_FIXED_PRIO_EN
            rr_ptr_q <= ~owner_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
      // Stray or misrouted beats are swallowed but remembered.
      if (flash_d_valid && flash_d_ready && !(state_q == WAIT_D && owner_hit)) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spiflash_tl_arbiter.sv
// Directed self-checking bench for spiflash_tl_arbiter; the bench plays both requesters and the
// flash controller.
module tb_spiflash_tl_arbiter;

  localparam int unsigned TL_RS = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       m0_a_size = '0, m1_a_size = '0;
  logic [TL_RS-1:0] m0_a_source = '0, m1_a_source = '0;
  logic [23:0]      m0_a_address = '0, m1_a_address = '0;
  logic             m0_a_valid = 1'b0, m1_a_valid = 1'b0;
  logic             m0_a_ready, m1_a_ready;
  logic [2:0]       m0_d_opcode, m1_d_opcode;
  logic [3:0]       m0_d_size, m1_d_size;
  logic [TL_RS-1:0] m0_d_source, m1_d_source;
  logic             m0_d_denied, m1_d_denied;
  logic [31:0]      m0_d_data, m1_d_data;
  logic             m0_d_corrupt, m1_d_corrupt;
  logic             m0_d_valid, m1_d_valid;
  logic             m0_d_ready = 1'b0, m1_d_ready = 1'b0;
  logic [3:0]       flash_a_size;
  logic [TL_RS:0]   flash_a_source;
  logic [23:0]      flash_a_address;
  logic             flash_a_valid;
  logic             flash_a_ready = 1'b1;
  logic [2:0]       flash_d_opcode = '0;
  logic [3:0]       flash_d_size = '0;
  logic [TL_RS:0]   flash_d_source = '0;
  logic             flash_d_denied = 1'b0;
  logic [31:0]      flash_d_data = '0;
  logic             flash_d_corrupt = 1'b0;
  logic             flash_d_valid = 1'b0;
  logic             flash_d_ready;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  spiflash_tl_arbiter #(.TL_RS(TL_RS), .MAX_SIZE(9)) dut (
    .flash_clock_i(clk), .flash_reset_i(rst),
    .m0_a_size(m0_a_size), .m0_a_source(m0_a_source), .m0_a_address(m0_a_address),
    .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready),
    .m0_d_opcode(m0_d_opcode), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_denied(m0_d_denied), .m0_d_data(m0_d_data), .m0_d_corrupt(m0_d_corrupt),
    .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready),
    .m1_a_size(m1_a_size), .m1_a_source(m1_a_source), .m1_a_address(m1_a_address),
    .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready),
    .m1_d_opcode(m1_d_opcode), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_denied(m1_d_denied), .m1_d_data(m1_d_data), .m1_d_corrupt(m1_d_corrupt),
    .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready),
    .flash_a_size(flash_a_size), .flash_a_source(flash_a_source),
    .flash_a_address(flash_a_address), .flash_a_valid(flash_a_valid),
    .flash_a_ready(flash_a_ready),
    .flash_d_opcode(flash_d_opcode), .flash_d_size(flash_d_size),
    .flash_d_source(flash_d_source), .flash_d_denied(flash_d_denied),
    .flash_d_data(flash_d_data), .flash_d_corrupt(flash_d_corrupt),
    .flash_d_valid(flash_d_valid), .flash_d_ready(flash_d_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input bit port, input bit v, input logic [3:0] size,
                         input logic [TL_RS-1:0] src, input logic [23:0] addr);
    if (port) begin
      m1_a_valid = v; m1_a_size = size; m1_a_source = src; m1_a_address = addr;
    end else begin
      m0_a_valid = v; m0_a_size = size; m0_a_source = src; m0_a_address = addr;
    end
  endtask

  // Expects the given port's request on flash_a_* this cycle, then takes the A handshake.
  task automatic expect_grant(input string tag, input bit port, input logic [3:0] size,
                              input logic [TL_RS-1:0] src, input logic [23:0] addr);
    #1;
    check(tag, {flash_a_valid, port ? m1_a_ready : m0_a_ready, port ? m0_a_ready : m1_a_ready,
                flash_a_source, flash_a_size, flash_a_address},
               {1'b1, 1'b1, 1'b0, port, src, size, addr});
    step();
  endtask

  // Streams n beats (data base+i) to the given port, optionally with its d_ready toggling.
  task automatic burst(input bit port, input int n, input logic [TL_RS-1:0] src,
                       input logic [31:0] base, input bit toggle);
    int beat = 0;
    bit rdy;
    logic own_v, oth_v;
    logic [TL_RS-1:0] own_s;
    logic [31:0] own_d;
    for (int cyc = 0; cyc < 4 * n + 8 && beat < n; cyc++) begin
      rdy = toggle ? cyc[0] : 1'b1;
      flash_d_valid  = 1'b1;
      flash_d_source = {port, src};
      flash_d_data   = base + beat;
      flash_d_opcode = 3'd1;
      flash_d_size   = 4'd2;
      m0_d_ready     = !port && rdy;
      m1_d_ready     = port && rdy;
      #1;
      own_v = port ? m1_d_valid : m0_d_valid;
      oth_v = port ? m0_d_valid : m1_d_valid;
      own_s = port ? m1_d_source : m0_d_source;
      own_d = port ? m1_d_data : m0_d_data;
      check("burst_beat",
            {flash_a_valid, m0_a_ready, m1_a_ready, flash_d_ready, own_v, oth_v, own_s, own_d},
            {1'b0, 1'b0, 1'b0, rdy, 1'b1, 1'b0, src, base + beat});
      step();
      if (rdy) beat++;
    end
    flash_d_valid = 1'b0;
    m0_d_ready    = 1'b0;
    m1_d_ready    = 1'b0;
    check("burst_len", beat, n);
  endtask

  initial begin
    bit p;
    // A request held during reset must not leak onto any output.
    set_req(0, 1, 4'd2, 3'd1, 24'h1);
    step();
    #1;
    check("rst_out", {flash_a_valid, m0_a_ready, m1_a_ready, flash_d_ready, m0_d_valid,
                      m1_d_valid, flash_a_source, m0_d_data}, 64'd0);
    check("rst_err", dut.err_q, 1'b0);
    step();
    rst = 1'b0;

    // Single-beat Get from m0.
    set_req(0, 1, 4'd2, 3'd5, 24'h000100);
    expect_grant("m0_grant", 0, 4'd2, 3'd5, 24'h000100);
    set_req(0, 0, 4'd0, 3'd0, 24'h0);
    flash_d_valid = 1'b1; flash_d_opcode = 3'd1; flash_d_size = 4'd2;
    flash_d_source = {1'b0, 3'd5}; flash_d_data = 32'hDEADBEEF; m0_d_ready = 1'b1;
    #1;
    check("m0_beat", {m0_d_valid, m1_d_valid, m0_d_opcode, m0_d_size, m0_d_source, m0_d_data,
                      flash_d_ready, m0_a_ready, flash_a_valid},
                     {1'b1, 1'b0, 3'd1, 4'd2, 3'd5, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0});
    step();
    // Stray beat while idle: dropped and flagged.
    flash_d_source = '0;
    #1;
    check("stray_drop", {flash_d_ready, m0_d_valid, m1_d_valid}, 3'b100);
    step();
    flash_d_valid = 1'b0; m0_d_ready = 1'b0;
    check("stray_err", dut.err_q, 1'b1);

    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_clear", dut.err_q, 1'b0);

    // Both requesters continuously competing with 4-beat bursts.
    for (int r = 0; r < 4; r++) begin
`ifdef SPIFLASH_ARB_FIXED_PRIO_EN
      p = 1'b0;
`else
      p = r[0];
`endif
      set_req(0, 1, 4'd4, 3'd1, 24'h10);
      set_req(1, 1, 4'd4, 3'd2, 24'h20);
      expect_grant("rr_grant", p, 4'd4, p ? 3'd2 : 3'd1, p ? 24'h20 : 24'h10);
      set_req(p, 0, 4'd0, 3'd0, 24'h0);
      burst(p, 4, p ? 3'd2 : 3'd1, 32'h1000 * (r + 1), 1'b0);
    end
    set_req(0, 0, 4'd0, 3'd0, 24'h0);
    set_req(1, 0, 4'd0, 3'd0, 24'h0);

    // A stalled m1 request keeps its grant when m0 arrives.
    flash_a_ready = 1'b0;
    set_req(1, 1, 4'd2, 3'd3, 24'h30);
    #1;
    check("lock_first", flash_a_source, {1'b1, 3'd3});
    step();
    set_req(0, 1, 4'd2, 3'd4, 24'h40);
    #1;
    check("lock_hold", {flash_a_source, m0_a_ready, m1_a_ready}, {1'b1, 3'd3, 1'b0, 1'b0});
    flash_a_ready = 1'b1;
    expect_grant("lock_grant", 1, 4'd2, 3'd3, 24'h30);
    set_req(1, 0, 4'd0, 3'd0, 24'h0);
    burst(1, 1, 3'd3, 32'h2000, 1'b0);
    expect_grant("after_lock", 0, 4'd2, 3'd4, 24'h40);
    set_req(0, 0, 4'd0, 3'd0, 24'h0);
    burst(0, 1, 3'd4, 32'h3000, 1'b0);

    // Maximum burst with throttled consumer; m0 waits with an oversized request.
    set_req(1, 1, 4'd9, 3'd6, 24'h800);
    expect_grant("big_grant", 1, 4'd9, 3'd6, 24'h800);
    set_req(1, 0, 4'd0, 3'd0, 24'h0);
    set_req(0, 1, 4'd10, 3'd7, 24'h900);
    burst(1, 128, 3'd6, 32'h5000_0000, 1'b1);

    // Oversized request is answered locally.
    #1;
    check("deny_a", {flash_a_valid, m0_a_ready}, 2'b01);
    step();
    set_req(0, 0, 4'd0, 3'd0, 24'h0);
    m0_d_ready = 1'b1;
    #1;
    check("deny_d", {m0_d_valid, m1_d_valid, m0_d_opcode, m0_d_size, m0_d_source, m0_d_denied,
                     m0_d_corrupt, m0_d_data, flash_a_valid},
                    {1'b1, 1'b0, 3'd1, 4'd10, 3'd7, 1'b1, 1'b1, 32'd0, 1'b0});
    step();
    m0_d_ready = 1'b0;
    set_req(1, 1, 4'd5, 3'd2, 24'hA00);
    #1;
    check("deny_idle", {m0_d_valid, flash_a_valid, flash_a_source}, {1'b0, 1'b1, 4'hA});

    // Reset during beat 3 of an 8-beat burst.
    expect_grant("pre_rst_grant", 1, 4'd5, 3'd2, 24'hA00);
    set_req(1, 0, 4'd0, 3'd0, 24'h0);
    burst(1, 2, 3'd2, 32'h7000, 1'b0);
    flash_d_valid = 1'b1; flash_d_source = {1'b1, 3'd2}; flash_d_data = 32'h7002;
    m1_d_ready = 1'b1; rst = 1'b1;
    #1;
    check("rst_mid", {m0_d_valid, m1_d_valid, flash_d_ready}, 3'b000);
    step();
    rst = 1'b0; flash_d_valid = 1'b0; m1_d_ready = 1'b0;
    #1;
    check("rst_after", {flash_a_valid, m0_d_valid, m1_d_valid}, 3'b000);
    set_req(0, 1, 4'd2, 3'd1, 24'hB00);
    set_req(1, 1, 4'd2, 3'd2, 24'hC00);
    expect_grant("fresh_grant", 0, 4'd2, 3'd1, 24'hB00);
    set_req(0, 0, 4'd0, 3'd0, 24'h0);
    burst(0, 1, 3'd1, 32'hCAFE, 1'b0);
    set_req(1, 0, 4'd0, 3'd0, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spiflash_tl_arbiter.md
# spiflash_tl_arbiter

Two-port TileLink-UL Get arbiter in front of the SPI flash controller, sharing its single A/D channel pair between two requesters (instruction fetch on port 0, data/loader on port 1). It grants one request at a time and holds the grant until every D beat of that burst has returned, then routes the beats back to the owner. It tags the downstream source with the owner index. It sits between the two requester ports and the flash controller's `flash_a_*`/`flash_d_*` interface.

## Interface
- `TL_RS`, 3: requester source width; downstream source width is `TL_RS+1`.
- `MAX_SIZE`, 9: largest legal `a_size`; 2^9 bytes = 128 words, matching the controller's response FIFO depth.
- `flash_clock_i`  in  1  clock; the only clock.
- `flash_reset_i`  in  1  reset; synchronous, active-high.
- `mN_a_size`/`mN_a_source`/`mN_a_address`  in  4/`TL_RS`/24  request from requester N (N=0,1).
- `mN_a_valid`  in  1 / `mN_a_ready`  out  1  request handshake.
- `mN_d_opcode`/`mN_d_size`/`mN_d_source`/`mN_d_denied`/`mN_d_data`/`mN_d_corrupt`  out  3/4/`TL_RS`/1/32/1  response to requester N.
- `mN_d_valid`  out  1 / `mN_d_ready`  in  1  response handshake.
- `flash_a_size`/`flash_a_source`/`flash_a_address`/`flash_a_valid`  out  4/`TL_RS+1`/24/1  request to the flash controller.
- `flash_a_ready`  in  1.
- `flash_d_opcode`/`flash_d_size`/`flash_d_source`/`flash_d_denied`/`flash_d_data`/`flash_d_corrupt`/`flash_d_valid`  in  as above, with source width `TL_RS+1`.
- `flash_d_ready`  out  1.

## Operation
- States:
  - IDLE: arbitrating.
  - WAIT_D: burst in flight, `owner` latched.
  - DENY: local error response pending.
- IDLE selection: if only one `mN_a_valid` is high, that requester is selected. If both are high, the requester selected is the one indicated by `rr_ptr`.
- Legal selected request (`a_size <= MAX_SIZE`):
  - `flash_a_*` is driven combinationally from the selected port.
  - `flash_a_source = {N, mN_a_source}`.
  - `mN_a_ready = flash_a_ready`.
  - On the A handshake: latch `owner=N` and load `beats`, then go to WAIT_D.
- Beat count: `beats = 1` for `a_size <= 2`; otherwise `beats = 2^(a_size-2)`. Held in an 8-bit down counter.
- WAIT_D:
  - `flash_a_valid = 0`; both `mN_a_ready = 0`.
  - `m[owner]_d_*` is driven from `flash_d_*`, with the source MSB stripped.
  - `m[owner]_d_valid = flash_d_valid`; `flash_d_ready = m[owner]_d_ready`.
  - Each D handshake decrements `beats`.
  - On the handshake with `beats == 1`: go to IDLE and set `rr_ptr = ~owner`.
- Illegal size (`a_size > MAX_SIZE`) while selected in IDLE:
  - `mN_a_ready = 1`; `flash_a_valid = 0`.
  - Latch `owner`, source and size, then go to DENY.
- DENY:
  - `m[owner]_d_valid = 1`, opcode 1 (AccessAckData), `denied = 1`, `corrupt = 1`, data 0, latched source/size.
  - On `m[owner]_d_ready`: go to IDLE and set `rr_ptr = ~owner`.
- A non-owner `d_valid` is always 0.
- `flash_d_valid` with source MSB ≠ `owner`, or any `flash_d_valid` outside WAIT_D, is a protocol violation. It is dropped with `flash_d_ready = 1`, and a sticky `err_q` bit is set (internal, visible to the bench).

## Timing
- Reset values:
  - state IDLE; `rr_ptr = 0`; `beats = 0`; `owner = 0`; `err_q = 0`.
  - All `*_d_valid = 0`, `flash_a_valid = 0`, `flash_d_ready = 0`, `mN_a_ready = 0`.
  - All other outputs are 0.
- Arbitration adds zero cycles: an IDLE-state request reaches `flash_a_valid` in the same cycle.
- D path adds zero cycles: beats pass through combinationally.
- Back-to-back bursts: after the last D handshake, the next A can issue in the following cycle (one IDLE cycle minimum).
- Selection is stable while `flash_a_valid` is high and unacknowledged: the selected port is frozen in `sel_q` from the first cycle of valid until the handshake, so a newly raised higher-priority valid cannot preempt it.
- Reset asserted mid-burst: the arbiter returns to IDLE next cycle and outstanding beats are abandoned. The flash controller shares the same reset.

## Configuration
- `SPIFLASH_ARB_FIXED_PRIO_EN`:
  - Defined: port 0 always wins simultaneous requests; `rr_ptr` is not implemented.
  - Undefined (default): round-robin via `rr_ptr` as above.

## Structure
- Package `spiflash_arb_pkg` holds:
  - `arb_state_e` {IDLE, WAIT_D, DENY}.
  - `MAX_SIZE` default constant.
  - Function `size_to_beats(logic [3:0])` returning `logic [7:0]`.
  - TileLink opcode constant `TL_ACCESS_ACK_DATA = 3'd1`.
- No sub-module: one arbiter module, ~200 lines.

## Test plan
- m0 Get size 2 @0x000100, flash returns 0xDEADBEEF: m0 gets one beat, opcode 1, source unchanged; m1_d_valid never asserts.
- m0 and m1 both valid after reset, each size 4: m0 is granted first (4 beats), then m1 (4 beats). Repeating gives alternation m1, m0.
- m1 size 9 burst with m1_d_ready toggling 50%: exactly 128 beats are delivered in order; m0 stays stalled (`m0_a_ready = 0`) throughout.
- m0 size 10: no `flash_a_valid`; m0 gets one beat with `denied = 1`, `corrupt = 1`, data 0; the arbiter is back in IDLE the following cycle.
- Reset pulsed during beat 3 of an 8-beat burst: all valids are 0 next cycle, and a fresh request is granted normally afterwards.
- With `SPIFLASH_ARB_FIXED_PRIO_EN` defined and both ports continuously valid: m0 wins every arbitration.
